ps2_rx_decoder: RTL and testbench
=================================

Name: ps2_rx_decoder

Overview:
- Upstream stage of the PS/2 keyboard register file.
- Receives raw PS/2 device frames on ps2_clk/ps2_data, validates them, and decodes the scan-code stream (make, break, extended).
- Produces the registered byte, the one-cycle interrupt pulse and the Caps Lock state consumed by the register file: ps2_byte, intp, caps_flg.

Parameters:
- TIMEOUT_CYC, 50000, max clk cycles between PS/2 falling edges inside a frame before abort (1 ms at 50 MHz).
- CNT_W, 16, width of timeout counter; must hold TIMEOUT_CYC.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low
- ps2_clk  input  1  raw PS/2 clock from pad, asynchronous
- ps2_data  input  1  raw PS/2 data from pad, asynchronous
- ps2_byte  output  8  last make scan code; held until next make
- intp  output  1  one-cycle pulse when ps2_byte updates with a new make code
- caps_flg  output  1  Caps Lock state; toggles on each fresh Caps make
- frame_err  output  1  one-cycle pulse on a discarded frame (bad stop, parity, timeout)

Behaviour:
- Reset values: ps2_byte=0x00, intp=0, caps_flg=0, frame_err=0, FSM=IDLE, brk=0, ext=0, caps_held=0, synchronisers=1.
- Input sync: ps2_clk and ps2_data each pass through a 2-FF synchroniser.
- Falling-edge strobe fe: previous synced clk=1 and current=0.
- Data is sampled on the fe cycle.
- Frame FSM, 11-bit frame, LSB first:
  - IDLE: on fe with data=0 (start) -> DATA, bit count=0. On fe with data=1 -> stay IDLE (spurious).
  - DATA: on each fe, shift data into shreg[7] (right shift). After 8 bits -> PARITY.
  - PARITY: on fe, latch parity bit -> STOP.
  - STOP: on fe, if data=1 the frame is valid -> decode. If data=0 -> frame_err pulse, discard. Either way -> IDLE.
- Timeout:
  - Counter clears on every fe and runs in all states except IDLE.
  - Reaching TIMEOUT_CYC-1 -> IDLE, frame_err pulse, brk and ext cleared.
- Decode: occurs in the cycle after the stop-bit fe; outputs register one cycle later.
  - Total latency: stop-bit pad edge to intp = 4 clk (2 sync + 1 edge + 1 decode).
  - 0xE0 -> ext=1, no intp.
  - 0xF0 -> brk=1, no intp.
  - Other code with brk=1 (release):
    - brk=0, ext=0, no intp.
    - If code==0x58 and ext==0, then caps_held=0.
  - Other code with brk=0 (make):
    - ps2_byte<=code, intp=1 for one cycle, ext=0.
    - If code==0x58, ext==0 and caps_held==0: caps_flg toggles and caps_held=1.
    - Typematic repeats of 0x58 while held do not toggle.
- Extended make codes (after E0) still update ps2_byte/intp; E0 58 never touches caps.
- Never more than one intp per frame. Frames are at least 11 PS/2 clocks apart, so intp can never be asserted on back-to-back cycles.
- Reset mid-frame: everything returns to reset values immediately (asynchronous); a partial frame is lost.

Optional Feature:
- Macro PS2_PARITY_CHK_EN.
- Defined: in STOP, a valid frame additionally requires XOR(shreg, parity bit)==1 (odd parity). On mismatch: frame_err pulse, byte discarded, no decode, brk/ext unchanged.
- Undefined: parity bit is latched but ignored; frame_err fires only for bad stop bit or timeout.

Decomposition:
- Shared include/package ps2_pkg:
  - SC_EXT=8'hE0, SC_BREAK=8'hF0, SC_CAPS=8'h58
  - FSM state encodings IDLE/DATA/PARITY/STOP (2-bit)
  - PS2_FRAME_BITS=11
- One sub-module: ps2_sync_edge, the 2-FF synchroniser for clk/data plus falling-edge strobe. Outputs data_s and fe.
- Frame FSM and scan-code decoder stay in ps2_rx_decoder.

Test Plan:
- Send frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) -> ps2_byte=0x1C, intp high exactly 1 clk, caps_flg=0, frame_err=0.
- Send F0,1C -> no intp for either frame; ps2_byte stays at prior value 0x1C; brk returns to 0.
- Send 58, 58, F0 58, 58 -> caps_flg 0->1 on first, unchanged on repeat, unchanged on release, 1->0 on next make; intp on each of the three makes.
- Send E0,58 -> ps2_byte=0x58, one intp, caps_flg unchanged.
- Send start plus 4 data bits, then hold ps2_clk high for TIMEOUT_CYC+10 cycles -> frame_err pulse, FSM IDLE; next full frame 0x1C decodes correctly.
- With PS2_PARITY_CHK_EN: send 0x1C with parity=1 -> frame_err pulse, no intp, ps2_byte unchanged. Without the macro, the same frame -> intp, ps2_byte=0x1C.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared scan-code constants, frame FSM encodings and frame length for the
// PS/2 receive path.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_CAPS  = 8'h58;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam int unsigned PS2_FRAME_BITS = 11;

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronisers for the PS/2 pad clock and data, plus a one-cycle
// strobe on each synchronised falling edge of the PS/2 clock.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic data_s_o,
  output logic fe_o
);

  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic data_meta_q, data_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk_i;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data_i;
      data_sync_q <= data_meta_q;
    end
  end

  assign data_s_o = data_sync_q;
  assign fe_o     = clk_prev_q & ~clk_sync_q;

endmodule

// File: rtl/ps2_rx_decoder.sv
// PS/2 device-to-host frame receiver and scan-code decoder (make/break/E0,
// Caps Lock tracking). Define PS2_PARITY_CHK_EN to reject odd-parity failures.
module ps2_rx_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ps2_byte,
  output logic       intp,
  output logic       caps_flg,
  output logic       frame_err
);

  logic data_s, fe;

  ps2_sync_edge u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk_i (ps2_clk),
    .ps2_data_i(ps2_data),
    .data_s_o  (data_s),
    .fe_o      (fe)
  );

  logic [1:0]       state_q, state_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             par_q, par_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_ok_q, frame_ok_d;
  logic             ferr_q, ferr_d;
  logic             timeout;
  logic             parity_ok;

`ifdef PS2_PARITY_CHK_EN
  assign parity_ok = ^{shreg_q, par_q};
`else
  logic unused_par;
  assign unused_par = par_q;
  assign parity_ok  = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    frame_ok_d = 1'b0;
    ferr_d     = 1'b0;
    timeout    = 1'b0;

    if (state_q == ST_IDLE || fe) cnt_d = '0;
    else                          cnt_d = cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (fe && !data_s) begin
          state_d  = ST_DATA;
          bitcnt_d = '0;
        end
      end
      ST_DATA: begin
        if (fe) begin
          shreg_d = {data_s, shreg_q[7:1]};
          if (bitcnt_q == 3'd7) state_d = ST_PARITY;
          else                  bitcnt_d = bitcnt_q + 1'b1;
        end
      end
      ST_PARITY: begin
        if (fe) begin
          par_d   = data_s;
          state_d = ST_STOP;
        end
      end
      default: begin
        if (fe) begin
          state_d = ST_IDLE;
          if (data_s && parity_ok) frame_ok_d = 1'b1;
          else                     ferr_d     = 1'b1;
        end
      end
    endcase

    // An edge in the same cycle restarts the inter-edge window, so it wins.
    if (state_q != ST_IDLE && !fe && cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
      state_d = ST_IDLE;
      ferr_d  = 1'b1;
      timeout = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      cnt_q      <= '0;
      frame_ok_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      cnt_q      <= cnt_d;
      frame_ok_q <= frame_ok_d;
      ferr_q     <= ferr_d;
    end
  end

  logic [7:0] byte_q, byte_d;
  logic       intp_q, intp_d;
  logic       caps_q, caps_d;
  logic       brk_q, brk_d;
  logic       ext_q, ext_d;
  logic       held_q, held_d;

  // shreg_q stays frozen in IDLE, so it still holds the code one cycle on.
  always_comb begin
    byte_d = byte_q;
    intp_d = 1'b0;
    caps_d = caps_q;
    brk_d  = brk_q;
    ext_d  = ext_q;
    held_d = held_q;

    if (timeout) begin
      brk_d = 1'b0;
      ext_d = 1'b0;
    end else if (frame_ok_q) begin
      if (shreg_q == SC_EXT) begin
        ext_d = 1'b1;
      end else if (shreg_q == SC_BREAK) begin
        brk_d = 1'b1;
      end else if (brk_q) begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        if (shreg_q == SC_CAPS && !ext_q) held_d = 1'b0;
      end else begin
        byte_d = shreg_q;
        intp_d = 1'b1;
        ext_d  = 1'b0;
        if (shreg_q == SC_CAPS && !ext_q && !held_q) begin
          caps_d = ~caps_q;
          held_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_q <= '0;
      intp_q <= 1'b0;
      caps_q <= 1'b0;
      brk_q  <= 1'b0;
      ext_q  <= 1'b0;
      held_q <= 1'b0;
    end else begin
      byte_q <= byte_d;
      intp_q <= intp_d;
      caps_q <= caps_d;
      brk_q  <= brk_d;
      ext_q  <= ext_d;
      held_q <= held_d;
    end
  end

  assign ps2_byte  = byte_q;
  assign intp      = intp_q;
  assign caps_flg  = caps_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_ps2_rx_decoder.sv
// Scoreboard bench for ps2_rx_decoder: frames are bit-banged on the PS/2 pins,
// expected make events queued at send time and checked as intp arrives.
module tb_ps2_rx_decoder;

  localparam int TMO  = 1000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] ps2_byte;
  logic       intp, caps_flg, frame_err;

  ps2_rx_decoder #(.TIMEOUT_CYC(TMO), .CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ps2_byte (ps2_byte),
    .intp     (intp),
    .caps_flg (caps_flg),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] b;
    logic       caps;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   fall_cyc = 0;
  int   ferr_cnt = 0;
  logic intp_prev = 1'b0;

  task automatic scoreboard_mon();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        intp_prev = 1'b0;
      end else begin
        if (frame_err) ferr_cnt++;
        if (intp) begin
          n_vec++;
          if (intp_prev) begin
            n_err++;
            $display("FAIL intp_width: intp high %0d cycles in a row, want 1", 2);
          end
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_intp: got byte %02h, want no intp", ps2_byte);
          end else begin
            e = exp_q.pop_front();
            if (ps2_byte !== e.b) begin
              n_err++;
              $display("FAIL ps2_byte: got %02h, want %02h", ps2_byte, e.b);
            end
            n_vec++;
            if (caps_flg !== e.caps) begin
              n_err++;
              $display("FAIL caps_flg: got %b, want %b (byte %02h)", caps_flg, e.caps, e.b);
            end
            n_vec++;
            if (cyc - fall_cyc != 4) begin
              n_err++;
              $display("FAIL latency: got %0d clk, want 4", cyc - fall_cyc);
            end
          end
        end
        intp_prev = intp;
      end
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    repeat (HALF) @(negedge clk);
    ps2_clk  = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(~bad_stop);
    repeat (30) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b, input logic caps);
    exp_t e;
    e.b = b;
    e.caps = caps;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    n_vec++;
    if ({ps2_byte, intp, caps_flg, frame_err} !== 11'h000) begin
      n_err++;
      $display("FAIL reset_outputs: got byte=%02h intp=%b caps=%b ferr=%b, want all 0",
               ps2_byte, intp, caps_flg, frame_err);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_vec++;
    if ({ps2_byte, intp, caps_flg, frame_err} !== 11'h000) begin
      n_err++;
      $display("FAIL idle_outputs: got byte=%02h intp=%b caps=%b ferr=%b, want all 0",
               ps2_byte, intp, caps_flg, frame_err);
    end
  endtask

  task automatic test_make();
    int f0 = ferr_cnt;
    push(8'h1C, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL make_missing: got %0d pending, want 0", exp_q.size());
      exp_q.delete();
    end
    n_vec++;
    if (ferr_cnt - f0 != 0) begin
      n_err++;
      $display("FAIL make_ferr: got %0d frame_err, want 0", ferr_cnt - f0);
    end
  endtask

  task automatic test_break();
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    n_vec++;
    if (ps2_byte !== 8'h1C) begin
      n_err++;
      $display("FAIL break_hold: got %02h, want 1c", ps2_byte);
    end
    push(8'h32, 1'b0);
    send_frame(8'h32, 1'b0, 1'b0);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL break_clear: got %0d pending, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_caps();
    push(8'h58, 1'b1);
    send_frame(8'h58, 1'b0, 1'b0);
    push(8'h58, 1'b1);
    send_frame(8'h58, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h58, 1'b0, 1'b0);
    n_vec++;
    if (caps_flg !== 1'b1) begin
      n_err++;
      $display("FAIL caps_release: got %b, want 1", caps_flg);
    end
    push(8'h58, 1'b0);
    send_frame(8'h58, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h58, 1'b0, 1'b0);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL caps_missing: got %0d pending, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_ext();
    push(8'h58, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h58, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h58, 1'b0, 1'b0);
    n_vec++;
    if (caps_flg !== 1'b0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL ext_caps: got caps=%b pending=%0d, want caps=0 pending=0",
               caps_flg, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_timeout();
    int f0;
    send_frame(8'hF0, 1'b0, 1'b0);
    f0 = ferr_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (TMO + 10) @(negedge clk);
    n_vec++;
    if (ferr_cnt - f0 != 1) begin
      n_err++;
      $display("FAIL timeout_ferr: got %0d frame_err, want 1", ferr_cnt - f0);
    end
    push(8'h1C, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    n_vec++;
    if (exp_q.size() != 0 || ferr_cnt - f0 != 1) begin
      n_err++;
      $display("FAIL timeout_recover: got pending=%0d ferr=%0d, want 0 and 1",
               exp_q.size(), ferr_cnt - f0);
      exp_q.delete();
    end
  endtask

  task automatic test_bad_stop();
    int f0 = ferr_cnt;
    send_frame(8'h22, 1'b0, 1'b1);
    n_vec++;
    if (ferr_cnt - f0 != 1 || ps2_byte !== 8'h1C) begin
      n_err++;
      $display("FAIL bad_stop: got ferr=%0d byte=%02h, want 1 and 1c", ferr_cnt - f0, ps2_byte);
    end
  endtask

  task automatic test_parity();
    int f0;
    push(8'h21, 1'b0);
    send_frame(8'h21, 1'b0, 1'b0);
    f0 = ferr_cnt;
`ifdef PS2_PARITY_CHK_EN
    send_frame(8'h1C, 1'b1, 1'b0);
    n_vec++;
    if (ferr_cnt - f0 != 1 || ps2_byte !== 8'h21) begin
      n_err++;
      $display("FAIL parity_reject: got ferr=%0d byte=%02h, want 1 and 21", ferr_cnt - f0, ps2_byte);
    end
`else
    push(8'h1C, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b0);
    n_vec++;
    if (ferr_cnt - f0 != 0 || ps2_byte !== 8'h1C) begin
      n_err++;
      $display("FAIL parity_ignore: got ferr=%0d byte=%02h, want 0 and 1c", ferr_cnt - f0, ps2_byte);
    end
`endif
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL parity_missing: got %0d pending, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_midframe();
    push(8'h58, 1'b1);
    send_frame(8'h58, 1'b0, 1'b0);
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({ps2_byte, caps_flg} !== 9'h000) begin
      n_err++;
      $display("FAIL async_reset: got byte=%02h caps=%b, want 00 and 0", ps2_byte, caps_flg);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    push(8'h1C, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL post_reset: got %0d pending, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    fork
      scoreboard_mon();
    join_none
    test_reset();
    test_make();
    test_break();
    test_caps();
    test_ext();
    test_timeout();
    test_bad_stop();
    test_parity();
    test_reset_midframe();
    repeat (10) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
